// File: rtl/hazard_pkg.sv
// Shared types for the LEGv8 forwarding/hazard unit: tracker entry layout and
// forward-select encoding helpers.
package hazard_pkg;

  // Wide enough for any practical register-address width; rd is zero-extended into it.
  localparam int ENTRY_RD_W = 8;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [ENTRY_RD_W-1:0] rd;
  } stage_entry_t;

  function automatic int fwd_sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Per-operand forwarding select: youngest matching in-flight writer wins,
// otherwise the regfile value; XZR always reads as zero.
module fwd_operand_mux
  import hazard_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int ZERO_REG   = 31,
  parameter int FWD_STAGES = 3,
  localparam int SEL_W     = fwd_sel_width(FWD_STAGES)
) (
  input  logic [ADDR_W-1:0]            src,
  input  logic                         src_used,
  input  stage_entry_t [FWD_STAGES-1:0] entries,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_result,
  input  logic [DATA_W-1:0]            rf_rdata,
  output logic [DATA_W-1:0]            op,
  output logic [SEL_W-1:0]             sel,
  output logic                         load_hit
);

  logic [FWD_STAGES-1:0] match;
  logic                  is_zero;
  logic                  found;

  assign is_zero  = (src == ADDR_W'(ZERO_REG));
  assign load_hit = match[0] & entries[0].memread;

  always_comb begin
    match = '0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      match[i] = entries[i].valid & entries[i].regwrite &
                 (entries[i].rd == ENTRY_RD_W'(src)) & ~is_zero & src_used;
    end
  end

  // A load sitting in EX has no data yet, so its stage-0 match is skipped.
  always_comb begin
    op    = rf_rdata;
    sel   = SEL_W'(FWD_SEL_RF);
    found = 1'b0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      if (!found && match[i] && !(i == 0 && load_hit)) begin
        found = 1'b1;
        sel   = SEL_W'(i + 1);
        op    = stage_result[i*DATA_W +: DATA_W];
      end
    end
    if (is_zero) begin
      op  = '0;
      sel = SEL_W'(FWD_SEL_RF);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding + load-use hazard unit for the pipelined LEGv8 core.
// Optional counters stall_cnt/fwd_cnt are built when HAZARD_STATS_EN is defined.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int ZERO_REG   = 31,
  parameter int FWD_STAGES = 3,
  localparam int SEL_W     = fwd_sel_width(FWD_STAGES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [ADDR_W-1:0]            id_rs1,
  input  logic [ADDR_W-1:0]            id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [ADDR_W-1:0]            id_rd,
  input  logic                         id_regwrite,
  input  logic                         id_memread,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            rf_rdata1,
  input  logic [DATA_W-1:0]            rf_rdata2,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_result,
  output logic [DATA_W-1:0]            op_a,
  output logic [DATA_W-1:0]            op_b,
  output logic [SEL_W-1:0]             fwd_sel_a,
  output logic [SEL_W-1:0]             fwd_sel_b,
  output logic                         stall,
  output logic                         cbz_zero
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  fwd_cnt
`endif
);

  stage_entry_t [FWD_STAGES-1:0] tracker;
  logic                          load_hit_a;
  logic                          load_hit_b;

  assign stall    = id_valid & (load_hit_a | load_hit_b);
  assign cbz_zero = (op_b == '0);

  // Flush or stall turns the instruction entering EX into a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tracker <= '0;
    end else begin
      if (id_valid && !stall && !flush) begin
        tracker[0] <= '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread,
                        rd: ENTRY_RD_W'(id_rd)};
      end else begin
        tracker[0] <= '0;
      end
      for (int i = 1; i < FWD_STAGES; i++) begin
        tracker[i] <= tracker[i-1];
      end
    end
  end

  fwd_operand_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .FWD_STAGES(FWD_STAGES)
  ) u_fwd_a (
    .src(id_rs1), .src_used(id_rs1_used), .entries(tracker), .stage_result(stage_result),
    .rf_rdata(rf_rdata1), .op(op_a), .sel(fwd_sel_a), .load_hit(load_hit_a)
  );

  fwd_operand_mux #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .FWD_STAGES(FWD_STAGES)
  ) u_fwd_b (
    .src(id_rs2), .src_used(id_rs2_used), .entries(tracker), .stage_result(stage_result),
    .rf_rdata(rf_rdata2), .op(op_b), .sel(fwd_sel_b), .load_hit(load_hit_b)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if ((fwd_sel_a != '0 || fwd_sel_b != '0) && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit (default parameters).
// Counter checks are included when HAZARD_STATS_EN is defined.
module tb_pipe_hazard_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         id_valid;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         id_rs1_used, id_rs2_used;
  logic         id_regwrite, id_memread;
  logic         flush;
  logic [63:0]  rf_rdata1, rf_rdata2;
  logic [191:0] stage_result;
  logic [63:0]  op_a, op_b;
  logic [1:0]   fwd_sel_a, fwd_sel_b;
  logic         stall, cbz_zero;
`ifdef HAZARD_STATS_EN
  logic [31:0]  stall_cnt, fwd_cnt;
`endif

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .stage_result(stage_result),
    .op_a(op_a), .op_b(op_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .cbz_zero(cbz_zero)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic fl);
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd;    id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setResult(input int idx, input logic [63:0] val);
    stage_result[idx*64 +: 64] = val;
  endtask

  // Advance one clock, then settle inputs just after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stage_result = '0;
    rf_rdata1 = 64'h111;
    rf_rdata2 = 64'h222;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_stall", 64'(stall), 64'd0);
    checkOutput("reset_sel_a", 64'(fwd_sel_a), 64'd0);
    checkOutput("reset_op_a", op_a, 64'h111);
    @(negedge clk);
    reset = 1'b0;

    // 1: ADD X1 then SUB X2,X1,X3
    nextCycle();
    applyStimulus(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0, 0);
    #1 checkOutput("t1_add_no_fwd", 64'(fwd_sel_a), 64'd0);
    nextCycle();
    applyStimulus(1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0, 0);
    setResult(0, 64'd5);
    #1;
    checkOutput("t1_sel_a", 64'(fwd_sel_a), 64'd1);
    checkOutput("t1_op_a", op_a, 64'd5);
    checkOutput("t1_stall", 64'(stall), 64'd0);
    checkOutput("t1_op_b_rf", op_b, 64'h222);

    // 2: LDUR X4 then ADD X5,X4,X4
    nextCycle();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd4, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd4, 1, 5'd4, 1, 5'd5, 1, 0, 0);
    #1;
    checkOutput("t2_stall", 64'(stall), 64'd1);
    checkOutput("t2_sel_a_suppressed", 64'(fwd_sel_a), 64'd0);
    nextCycle();
    setResult(1, 64'hDEAD);
    #1;
    checkOutput("t2_stall_released", 64'(stall), 64'd0);
    checkOutput("t2_sel_a", 64'(fwd_sel_a), 64'd2);
    checkOutput("t2_sel_b", 64'(fwd_sel_b), 64'd2);
    checkOutput("t2_op_a", op_a, 64'hDEAD);
    checkOutput("t2_op_b", op_b, 64'hDEAD);

    // 3: X6 at stage0 and stage2, XZR writer in between
    nextCycle();
    applyStimulus(1, 5'd9, 1, 5'd9, 1, 5'd6, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd9, 1, 5'd9, 1, 5'd31, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd9, 1, 5'd9, 1, 5'd6, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd6, 1, 5'd6, 0, 5'd10, 1, 0, 0);
    setResult(0, 64'd7);
    setResult(1, 64'h55);
    setResult(2, 64'd9);
    #1;
    checkOutput("t3_youngest_sel", 64'(fwd_sel_a), 64'd1);
    checkOutput("t3_youngest_op", op_a, 64'd7);
    checkOutput("t3_rs2_unused", op_b, 64'h222);
    nextCycle();
    applyStimulus(1, 5'd31, 1, 5'd6, 1, 5'd0, 0, 0, 0);
    setResult(1, 64'h66);
    #1;
    checkOutput("t3_xzr_op", op_a, 64'd0);
    checkOutput("t3_xzr_sel", 64'(fwd_sel_a), 64'd0);
    checkOutput("t3_rs2_stage1", op_b, 64'h66);

    // 4: flushed LDUR X12 must not create a hazard
    nextCycle();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd12, 1, 1, 1);
    nextCycle();
    applyStimulus(1, 5'd12, 1, 5'd12, 1, 5'd13, 1, 0, 0);
    #1;
    checkOutput("t4_no_stall", 64'(stall), 64'd0);
    checkOutput("t4_op_a_rf", op_a, 64'h111);

    // 5: reset in the middle of a load-use stall
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 5'd13, 1, 1, 0);
    nextCycle();
    applyStimulus(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 0, 0);
    #1 checkOutput("t5_stall_before", 64'(stall), 64'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5_stall_async", 64'(stall), 64'd0);
    checkOutput("t5_op_a_rf", op_a, 64'h111);
    @(negedge clk);
    reset = 1'b0;

    // 6: CBZ X7 with X7 in MEM producing zero
    nextCycle();
    applyStimulus(1, 5'd0, 0, 5'd9, 1, 5'd7, 1, 0, 0);
    rf_rdata2 = 64'd3;
    nextCycle();
    applyStimulus(0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 0);
    #1 checkOutput("t6_cbz_nonzero", 64'(cbz_zero), 64'd0);
    nextCycle();
    applyStimulus(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0);
    setResult(1, 64'd0);
    #1;
    checkOutput("t6_cbz_zero", 64'(cbz_zero), 64'd1);
    checkOutput("t6_sel_b", 64'(fwd_sel_b), 64'd2);

`ifdef HAZARD_STATS_EN
    // Three load-use pairs after a fresh reset: one stall and one forward each.
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      applyStimulus(1, 5'd20, 1, 5'd0, 0, 5'd14, 1, 1, 0);
      nextCycle();
      applyStimulus(1, 5'd14, 1, 5'd0, 0, 5'd0, 0, 0, 0);
      nextCycle();
      #1 checkOutput("stats_fwd_sel", 64'(fwd_sel_a), 64'd2);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("stats_stall_cnt", 64'(stall_cnt), 64'd3);
    checkOutput("stats_fwd_cnt", 64'(fwd_cnt), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
